// File: rtl/mult_arbiter.sv
// mult_arbiter
//   Four-way round-robin arbiter in front of one shared multi-cycle
//   multiplier. A requester is granted in IDLE, its operands are latched,
//   the multiplier is started, and the owner gets either a done pulse with
//   the product in `result` or an err pulse if the multiplier never
//   reports busy.
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-low reset
//   req       in   [3:0]    request level per requester
//   op_a      in   [4*W-1:0] operand A, requester i at [i*W +: W]
//   op_b      in   [4*W-1:0] operand B, requester i at [i*W +: W]
//   gnt       out  [3:0]    one-hot owner, 0 when idle
//   done      out  [3:0]    one-cycle result-valid pulse to owner
//   err       out  [3:0]    one-cycle timeout pulse to owner
//   result    out  [2W-1:0] product register, held until next capture
//   busy      out  high whenever not idle
//   mul_en    out  start strobe to the multiplier
//   mul_a/b   out  [W-1:0]  latched operands to the multiplier
//   mul_r     in   [2W-1:0] multiplier product
//   mul_busy  in   multiplier busy flag
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; arbitrate among req, gnt = 0
// START | mul_en high; wait for mul_busy, time out after TMO cycles
// WAIT  | multiplier running; leave on first cycle mul_busy = 0
// CAPT  | result holds the product; done pulses to owner, then IDLE

module mult_arbiter #(
    parameter int W   = 16,
    parameter int TMO = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [4*W-1:0]   op_a,
    input  logic [4*W-1:0]   op_b,
    output logic [3:0]       gnt,
    output logic [3:0]       done,
    output logic [3:0]       err,
    output logic [2*W-1:0]   result,
    output logic             busy,
    output logic             mul_en,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    input  logic [2*W-1:0]   mul_r,
    input  logic             mul_busy
);

    localparam int CW = (TMO < 1) ? 1 : $clog2(TMO + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_CAPT  = 2'd3;

    logic [1:0]     state_q,  state_d;
    logic [1:0]     owner_q,  owner_d;
    logic [1:0]     last_q,   last_d;
    logic [3:0]     gnt_q,    gnt_d;
    logic [3:0]     err_q,    err_d;
    logic [2*W-1:0] result_q, result_d;
    logic [W-1:0]   mul_a_q,  mul_a_d;
    logic [W-1:0]   mul_b_q,  mul_b_d;
    logic [CW-1:0]  cnt_q,    cnt_d;

    logic [1:0]     pick;
    logic           pick_valid;
    logic [1:0]     idx;

    // Round-robin pick: first set req bit starting just after the last owner.
    always_comb begin
        pick       = 2'd0;
        pick_valid = 1'b0;
        idx        = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!pick_valid && req[idx]) begin
                pick       = idx;
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        err_d    = 4'b0000;
        result_d = result_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick;
                    gnt_d   = 4'b0001 << pick;
                    mul_a_d = op_a[pick*W +: W];
                    mul_b_d = op_b[pick*W +: W];
                    // Timeout is a down-counter; terminal count is 1.
                    cnt_d   = CW'(TMO);
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (mul_busy) begin
                    state_d = ST_WAIT;
                end else if (cnt_q <= CW'(1)) begin
                    err_d   = gnt_q;
                    gnt_d   = 4'b0000;
                    last_d  = owner_q;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_WAIT: begin
                // Product is latched on entry to CAPT so it is already
                // visible in the same cycle as the done pulse.
                if (!mul_busy) begin
                    result_d = mul_r;
                    state_d  = ST_CAPT;
                end
            end
            ST_CAPT: begin
                gnt_d   = 4'b0000;
                last_d  = owner_q;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = 4'b0000;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= 2'd0;
            last_q   <= 2'd3;
            gnt_q    <= 4'b0000;
            err_q    <= 4'b0000;
            result_q <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            err_q    <= err_d;
            result_q <= result_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            cnt_q    <= cnt_d;
        end
    end

    assign gnt    = gnt_q;
    assign err    = err_q;
    assign result = result_q;
    assign mul_a  = mul_a_q;
    assign mul_b  = mul_b_q;
    assign busy   = (state_q != ST_IDLE);
    assign mul_en = (state_q == ST_START);
    assign done   = (state_q == ST_CAPT) ? gnt_q : 4'b0000;

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;

    localparam int W   = 16;
    localparam int TMO = 15;
    localparam int LAT = 17;

    logic          clk;
    logic          rst;
    logic [3:0]    req;
    logic [4*W-1:0] op_a;
    logic [4*W-1:0] op_b;
    logic [3:0]    gnt;
    logic [3:0]    done;
    logic [3:0]    err;
    logic [2*W-1:0] result;
    logic          busy;
    logic          mul_en;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic [2*W-1:0] mul_r;
    logic          mul_busy;

    int n_checks;
    int n_fail;
    logic mon_en;

    mult_arbiter #(.W(W), .TMO(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .op_a     (op_a),
        .op_b     (op_b),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .result   (result),
        .busy     (busy),
        .mul_en   (mul_en),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_r    (mul_r),
        .mul_busy (mul_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: starts on mul_en, busy for LAT cycles, signed product.
    logic        mb_enable;
    logic [4:0]  mb_cnt;
    logic [31:0] mb_prod;

    always @(posedge clk) begin
        if (!rst) begin
            mul_busy <= 1'b0;
            mb_cnt   <= 5'd0;
            mul_r    <= 32'd0;
            mb_prod  <= 32'd0;
        end else if (mul_busy) begin
            if (mb_cnt == 5'd1) begin
                mul_busy <= 1'b0;
                mul_r    <= mb_prod;
            end else begin
                mb_cnt <= mb_cnt - 5'd1;
            end
        end else if (mul_en && mb_enable) begin
            mul_busy <= 1'b1;
            mb_cnt   <= 5'(LAT);
            mb_prod  <= 32'($signed(mul_a)) * 32'($signed(mul_b));
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if ((done & err) !== 4'b0000 ||
                ((busy === 1'b1) ? !$onehot(gnt) : (gnt !== 4'b0000))) begin
                n_fail++;
                $display("FAIL invariant busy=%b gnt=%b done=%b err=%b", busy, gnt, done, err);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        req       = 4'b0000;
        mb_enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        op_a = 64'h1234_5678_9abc_def0;
        op_b = 64'h0fed_cba9_8765_4321;
        do_reset();
        n_checks++;
        if ({gnt, done, err, busy, mul_en} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl got gnt=%b done=%b err=%b busy=%b mul_en=%b want all 0",
                     gnt, done, err, busy, mul_en);
        end
        n_checks++;
        if (result !== 32'd0 || mul_a !== 16'd0 || mul_b !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_data got result=%h mul_a=%h mul_b=%h want 0", result, mul_a, mul_b);
        end
    endtask

    task automatic test_single();
        int en_cnt;
        int at;
        bit ok;
        do_reset();
        op_a = '0; op_b = '0;
        op_a[15:0] = 16'd3;
        op_b[15:0] = 16'd5;
        req = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0001 || mul_en !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant got gnt=%b mul_en=%b busy=%b want 0001 1 1", gnt, mul_en, busy);
        end
        req = 4'b0000;   // dropping req mid-operation must not abort
        en_cnt = 1; at = 0; ok = 1'b0;
        for (int c = 2; c <= 60 && !ok; c++) begin
            @(negedge clk);
            if (mul_en === 1'b1) en_cnt++;
            if (done !== 4'b0000) begin ok = 1'b1; at = c; end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_done_wait got no done in 60 cycles want done");
        end
        n_checks++;
        if (done !== 4'b0001 || result !== 32'd15) begin
            n_fail++;
            $display("FAIL single_result got done=%b result=%0d want 0001 15", done, result);
        end
        n_checks++;
        if (at !== 20 || en_cnt !== 2) begin
            n_fail++;
            $display("FAIL single_latency got done_cycle=%0d mul_en_cycles=%0d want 20 2", at, en_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 4'b0000 || gnt !== 4'b0000 || busy !== 1'b0 || result !== 32'd15) begin
            n_fail++;
            $display("FAIL single_after got done=%b gnt=%b busy=%b result=%0d want 0 0 0 15",
                     done, gnt, busy, result);
        end
    endtask

    localparam logic [3:0]  RR_DONE [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    localparam logic [31:0] RR_PROD [5] = '{32'd22, 32'd60, 32'd104, 32'd154, 32'd22};

    task automatic test_round_robin();
        bit ok;
        do_reset();
        // a_i = 3i+2, b_i = i+11
        op_a = {16'd11, 16'd8, 16'd5, 16'd2};
        op_b = {16'd14, 16'd13, 16'd12, 16'd11};
        req  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            ok = 1'b0;
            for (int c = 0; c < 60 && !ok; c++) begin
                @(negedge clk);
                if (done !== 4'b0000) ok = 1'b1;
            end
            n_checks++;
            if (!ok || done !== RR_DONE[k] || result !== RR_PROD[k] || gnt !== RR_DONE[k]) begin
                n_fail++;
                $display("FAIL rr_op%0d got done=%b gnt=%b result=%0d want %b %b %0d",
                         k, done, gnt, result, RR_DONE[k], RR_DONE[k], RR_PROD[k]);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_signed();
        bit ok;
        do_reset();
        op_a = '0; op_b = '0;
        op_a[47:32] = 16'h8000;
        op_b[47:32] = 16'h0002;
        req = 4'b0100;
        ok = 1'b0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk);
            if (done !== 4'b0000) ok = 1'b1;
        end
        req = 4'b0000;
        n_checks++;
        if (!ok || done !== 4'b0100 || result !== 32'hFFFF0000) begin
            n_fail++;
            $display("FAIL signed got done=%b result=%h want 0100 ffff0000", done, result);
        end
    endtask

    task automatic test_timeout();
        int en_cnt;
        bit saw_done;
        bit ok;
        do_reset();
        mb_enable = 1'b0;
        op_a = '0; op_b = '0;
        req = 4'b0100;
        en_cnt = 0; saw_done = 1'b0; ok = 1'b0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            if (mul_en === 1'b1) en_cnt++;
            if (done !== 4'b0000) saw_done = 1'b1;
            if (err !== 4'b0000) ok = 1'b1;
        end
        n_checks++;
        if (!ok || err !== 4'b0100 || en_cnt !== TMO) begin
            n_fail++;
            $display("FAIL timeout_err got err=%b start_cycles=%0d want 0100 %0d", err, en_cnt, TMO);
        end
        n_checks++;
        if (saw_done || gnt !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_state got saw_done=%b gnt=%b busy=%b want 0 0000 0", saw_done, gnt, busy);
        end
        mb_enable = 1'b1;
        op_a[15:0] = 16'd6;
        op_b[15:0] = 16'd7;
        req = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (err !== 4'b0000 || gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL timeout_next_grant got err=%b gnt=%b want 0000 0001", err, gnt);
        end
        req = 4'b0000;
        ok = 1'b0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk);
            if (done !== 4'b0000) ok = 1'b1;
        end
        n_checks++;
        if (!ok || done !== 4'b0001 || result !== 32'd42) begin
            n_fail++;
            $display("FAIL timeout_recover got done=%b result=%0d want 0001 42", done, result);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        do_reset();
        op_a = '0; op_b = '0;
        op_a[31:16] = 16'd4;
        op_b[31:16] = 16'd9;
        req = 4'b0010;
        ok = 1'b0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk);
            if (done !== 4'b0000) ok = 1'b1;
        end
        n_checks++;
        if (!ok || done !== 4'b0010 || result !== 32'd36) begin
            n_fail++;
            $display("FAIL rstwait_first got done=%b result=%0d want 0010 36", done, result);
        end
        // req stays high, so requester 1 is granted again; find its WAIT phase
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (mul_busy === 1'b1 && mul_en === 1'b0 && busy === 1'b1) ok = 1'b1;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rstwait_reach got no WAIT phase want WAIT within 20 cycles");
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (done !== 4'b0000 || err !== 4'b0000 || gnt !== 4'b0000 || result !== 32'd0 ||
            mul_en !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstwait_abandon got done=%b err=%b gnt=%b result=%0d mul_en=%b busy=%b want all 0",
                     done, err, gnt, result, mul_en, busy);
        end
        rst = 1'b1;
        op_b[31:16] = 16'd10;
        ok = 1'b0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk);
            if (done !== 4'b0000) ok = 1'b1;
        end
        req = 4'b0000;
        n_checks++;
        if (!ok || done !== 4'b0010 || result !== 32'd40) begin
            n_fail++;
            $display("FAIL rstwait_restart got done=%b result=%0d want 0010 40", done, result);
        end
    endtask

    task automatic test_operand_change();
        bit ok;
        do_reset();
        op_a = '0; op_b = '0;
        op_a[15:0] = 16'd7;
        op_b[15:0] = 16'd9;
        req = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL opchg_grant got gnt=%b want 0001", gnt);
        end
        op_a[15:0] = 16'd100;
        op_b[15:0] = 16'd1;
        req = 4'b0000;
        @(negedge clk);
        n_checks++;
        if (mul_a !== 16'd7 || mul_b !== 16'd9) begin
            n_fail++;
            $display("FAIL opchg_hold got mul_a=%0d mul_b=%0d want 7 9", mul_a, mul_b);
        end
        ok = 1'b0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk);
            if (done !== 4'b0000) ok = 1'b1;
        end
        n_checks++;
        if (!ok || done !== 4'b0001 || result !== 32'd63) begin
            n_fail++;
            $display("FAIL opchg_result got done=%b result=%0d want 0001 63", done, result);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        mon_en    = 1'b0;
        rst       = 1'b0;
        req       = 4'b0000;
        op_a      = '0;
        op_b      = '0;
        mb_enable = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_signed();
        test_timeout();
        test_reset_mid_wait();
        test_operand_change();
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
